// File: rtl/irrigation_scheduler_if.sv
// Handshake bundle between the scheduler, its two job requesters and the
// pump/valve executor.
//   host_valid/host_job/host_ready : host command decoder job offer
//   auto_valid/auto_job/auto_ready : moisture trigger job offer
//   sched_enable, flush            : scheduler control
//   exec_start + exec_* fields     : job dispatch to the executor
//   exec_busy                      : executor running a job
// slave = scheduler side, master = requester/executor side.
interface irrigation_scheduler_if;
   logic        host_valid;
   logic [21:0] host_job;
   logic        host_ready;
   logic        auto_valid;
   logic [21:0] auto_job;
   logic        auto_ready;
   logic        sched_enable;
   logic        flush;
   logic        exec_start;
   logic        exec_action;
   logic [4:0]  exec_pump_time;
   logic [7:0]  exec_position;
   logic [7:0]  exec_distance;
   logic        exec_busy;

   modport slave (
      input  host_valid, host_job, auto_valid, auto_job, sched_enable, flush, exec_busy,
      output host_ready, auto_ready, exec_start, exec_action, exec_pump_time,
             exec_position, exec_distance
   );

   modport master (
      output host_valid, host_job, auto_valid, auto_job, sched_enable, flush, exec_busy,
      input  host_ready, auto_ready, exec_start, exec_action, exec_pump_time,
             exec_position, exec_distance
   );
endinterface

// File: rtl/irrigation_scheduler.sv
// Watering job scheduler: queues jobs from the host and the auto trigger,
// arbitrates round-robin when only one slot is free, and dispatches one job at
// a time to the executor with a start/busy handshake, a settle gap after each
// job and a timeout that drops jobs the executor never acknowledges.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   bus           : requester/executor handshake (slave side)
//   queue_count   : entries stored
//   sched_busy    : FSM not idle
//   err_timeout   : 1-cycle pulse when a job is dropped for lack of ack
//   err_count     : saturating count of dropped jobs
module irrigation_scheduler #(
   parameter int          DEPTH       = 4,
   parameter int          ADDR_W      = 2,
   parameter logic [23:0] GAP_CYCLES  = 24'd10_000_000,
   parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
   input  logic                 clock,
   input  logic                 reset,
   irrigation_scheduler_if.slave bus,
   output logic [ADDR_W:0]      queue_count,
   output logic                 sched_busy,
   output logic                 err_timeout,
   output logic [7:0]           err_count
);
   typedef enum logic [2:0] {IDLE, ISSUE, ACK, RUN, GAP} state_t;

   localparam logic [ADDR_W:0] FULL    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] FULL_M2 = (ADDR_W+1)'(DEPTH - 2);

   state_t              state, next;
   logic [21:0]         mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic                rr_auto;     // 1: auto wins the next contended single slot
   logic [23:0]         tmr;         // cycles spent in the current state
   logic [24:0]         tmr_inc;
   logic                can_acc, contend, issue_go;
   logic [ADDR_W:0]     n_acc;

   // Contention only matters when exactly one slot is left; with two or more
   // free both sides go in together, host first.
   assign can_acc        = !bus.flush && (queue_count < FULL);
   assign contend        = bus.host_valid && bus.auto_valid && (queue_count > FULL_M2);
   assign bus.host_ready = can_acc && bus.host_valid && (!contend || !rr_auto);
   assign bus.auto_ready = can_acc && bus.auto_valid && (!contend ||  rr_auto);
   assign n_acc          = (ADDR_W+1)'(bus.host_ready) + (ADDR_W+1)'(bus.auto_ready);

   // Pop happens on the IDLE->ISSUE edge so exec_* are already valid while
   // exec_start is high. A flush in the same cycle wins over the pop.
   assign issue_go   = (state == IDLE) && bus.sched_enable && (queue_count != '0) &&
                       !bus.exec_busy && !bus.flush;
   assign sched_busy = (state != IDLE);
   assign tmr_inc    = {1'b0, tmr} + 25'd1;

   always_ff @(posedge clock) begin
      if (bus.host_ready) mem[wr_ptr] <= bus.host_job;
      if (bus.auto_ready) mem[wr_ptr + ADDR_W'(bus.host_ready)] <= bus.auto_job;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         queue_count <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rr_auto     <= 1'b0;
      end else begin
         if (bus.flush) begin
            queue_count <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
         end else begin
            queue_count <= queue_count + n_acc - (ADDR_W+1)'(issue_go);
            wr_ptr      <= wr_ptr + ADDR_W'(n_acc);
            rd_ptr      <= rd_ptr + ADDR_W'(issue_go);
         end
         if (contend && bus.host_ready) rr_auto <= 1'b1;
         if (contend && bus.auto_ready) rr_auto <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= IDLE;
         tmr                <= '0;
         bus.exec_start     <= 1'b0;
         bus.exec_action    <= 1'b0;
         bus.exec_pump_time <= '0;
         bus.exec_position  <= '0;
         bus.exec_distance  <= '0;
         err_count          <= '0;
      end else begin
         state          <= next;
         tmr            <= (next != state) ? '0 : tmr + 24'd1;
         bus.exec_start <= issue_go;
         if (issue_go)
            {bus.exec_action, bus.exec_pump_time, bus.exec_position, bus.exec_distance} <= mem[rd_ptr];
         if (err_timeout && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
      end
   end

   always_comb begin
      next        = state;
      err_timeout = 1'b0;
      case (state)
         IDLE:  if (issue_go) next = ISSUE;
         ISSUE: next = ACK;
         ACK: begin
            if (bus.exec_busy) next = RUN;
            else if (tmr_inc >= {9'd0, ACK_TIMEOUT}) begin
               next        = GAP;
               err_timeout = 1'b1;
            end
         end
         RUN:   if (!bus.exec_busy) next = GAP;
         // tmr_inc >= 1 always, so a zero gap still spends one cycle here
         GAP:   if (tmr_inc >= {1'b0, GAP_CYCLES}) next = IDLE;
         default: next = IDLE;
      endcase
   end
endmodule
